// File: rtl/pe_pool_packer_if.sv
// Bus between the PE result stream, the pool/pack stage and its word consumer.
interface pe_pool_packer_if #(
  parameter int unsigned CELL_BIT = 8,
  parameter int unsigned N_PACK   = 4
);
  logic [CELL_BIT-1:0]        in_data;
  logic                       in_en;
  logic                       relu_en;
  logic [1:0]                 pool_len;
  logic                       flush;
  logic [CELL_BIT*N_PACK-1:0] out_word;
  logic [2:0]                 out_count;
  logic                       out_valid;
  logic                       out_ready;
  logic                       overflow;

  modport master (
    output in_data, in_en, relu_en, pool_len, flush, out_ready,
    input  out_word, out_count, out_valid, overflow
  );

  modport slave (
    input  in_data, in_en, relu_en, pool_len, flush, out_ready,
    output out_word, out_count, out_valid, overflow
  );
endinterface

// File: rtl/pe_pool_packer.sv
// PE output stage: optional ReLU, signed max-pool of 1..4 samples, pack four
// pooled bytes per word, buffer words in a small FIFO with sticky overflow.
module pe_pool_packer #(
  parameter int unsigned cell_bit   = 8,
  parameter int unsigned N_pack     = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  pe_pool_packer_if.slave   bus
);
  localparam int unsigned WORD_W = cell_bit * N_pack;
  localparam int unsigned LW     = $clog2(N_pack);
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned ENT_W  = WORD_W + 3;

  logic [cell_bit-1:0] r_acc;
  logic [1:0]          r_pcnt;
  logic [1:0]          r_plen_q;
  logic [cell_bit-1:0] r_lane [N_pack];
  logic [LW-1:0]       r_lcnt;
  logic [ENT_W-1:0]    r_mem  [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_cnt;
  logic                r_overflow;

  logic [cell_bit-1:0] w_v;
  logic [cell_bit-1:0] w_cand;
  logic [cell_bit-1:0] w_close_val;
  logic [1:0]          w_eff_len;
  logic                w_close_nat;
  logic                w_close;
  logic [2:0]          w_bytes;
  logic                w_push;
  logic [cell_bit-1:0] w_lane [N_pack];
  logic [WORD_W-1:0]   w_word;
  logic                w_valid;
  logic                w_full;
  logic                w_pop;
  logic                w_wr;

  // Window datapath: the first sample of a window latches its own pool length.
  assign w_v         = (bus.relu_en && bus.in_data[cell_bit-1]) ? '0 : bus.in_data;
  assign w_eff_len   = (r_pcnt == 2'd0) ? bus.pool_len : r_plen_q;
  assign w_cand      = (r_pcnt == 2'd0) ? w_v :
                       (($signed(r_acc) > $signed(w_v)) ? r_acc : w_v);
  assign w_close_nat = bus.in_en && (r_pcnt == w_eff_len);
  // Flush closes whatever window is open after this cycle's sample.
  assign w_close     = w_close_nat || (bus.flush && (bus.in_en || (r_pcnt != 2'd0)));
  assign w_close_val = bus.in_en ? w_cand : r_acc;
  assign w_bytes     = 3'(r_lcnt) + 3'(w_close);
  assign w_push      = (w_close && (r_lcnt == LW'(N_pack - 1))) ||
                       (bus.flush && (w_bytes != 3'd0));

  // Outgoing word includes the byte closing on this edge; unused lanes are zero.
  always_comb begin
    w_lane = r_lane;
    if (w_close) w_lane[r_lcnt] = w_close_val;
    w_word = '0;
    for (int i = 0; i < int'(N_pack); i++)
      w_word[WORD_W-1-i*cell_bit -: cell_bit] = w_lane[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc    <= '0;
      r_pcnt   <= '0;
      r_plen_q <= '0;
      r_lcnt   <= '0;
      for (int i = 0; i < int'(N_pack); i++) r_lane[i] <= '0;
    end else begin
      if (bus.in_en && (r_pcnt == 2'd0)) r_plen_q <= bus.pool_len;
      if (w_close) begin
        r_pcnt <= '0;
      end else if (bus.in_en) begin
        r_acc  <= w_cand;
        r_pcnt <= r_pcnt + 2'd1;
      end
      if (w_push) begin
        r_lcnt <= '0;
        for (int i = 0; i < int'(N_pack); i++) r_lane[i] <= '0;
      end else if (w_close) begin
        r_lane[r_lcnt] <= w_close_val;
        r_lcnt         <= r_lcnt + LW'(1);
      end
    end
  end

  // FIFO: a pop frees a slot for a same-cycle push even when full.
  assign w_valid = (r_cnt != '0);
  assign w_full  = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_pop   = w_valid && bus.out_ready;
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= {w_bytes, w_word};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_pop)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (!w_wr && w_pop) r_cnt <= r_cnt - (AW+1)'(1);
      if (w_push && !w_wr) r_overflow <= 1'b1;
    end
  end

  assign bus.out_valid = w_valid;
  assign bus.out_word  = w_valid ? r_mem[r_rd_ptr][WORD_W-1:0] : '0;
  assign bus.out_count = w_valid ? r_mem[r_rd_ptr][ENT_W-1:WORD_W] : 3'd0;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_pe_pool_packer.sv
// Directed bench for pe_pool_packer: ReLU, pooling, flush, backpressure, overflow, reset.
module tb_pe_pool_packer;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  pe_pool_packer_if bus ();

  pe_pool_packer #(.cell_bit(8), .N_pack(4), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    bus.in_data = d;
    bus.in_en   = 1'b1;
    tick();
    bus.in_en   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.out_word !== 32'h0) begin errors++; $display("FAIL reset_word got %h exp 00000000", bus.out_word); end
    checks++; if (bus.out_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bus.out_count); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", bus.overflow); end
  endtask

  task automatic test_relu();
    bus.pool_len = 2'd0; bus.relu_en = 1'b1; bus.out_ready = 1'b1;
    send(8'h05); send(8'hF0); send(8'h7F);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL relu_early_valid got %b exp 0", bus.out_valid); end
    send(8'h80);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL relu_valid got %b exp 1", bus.out_valid); end
    checks++; if (bus.out_word !== 32'h05007F00) begin errors++; $display("FAIL relu_word got %h exp 05007F00", bus.out_word); end
    checks++; if (bus.out_count !== 3'd4) begin errors++; $display("FAIL relu_count got %0d exp 4", bus.out_count); end
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL relu_one_cycle got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_pool();
    logic [7:0] s [8];
    s = '{8'hFE, 8'hFC, 8'h03, 8'h80, 8'h80, 8'h81, 8'h10, 8'h10};
    bus.pool_len = 2'd1; bus.relu_en = 1'b0; bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(s[i]);
    checks++; if (bus.out_word !== 32'hFE038110) begin errors++; $display("FAIL pool_word got %h exp FE038110", bus.out_word); end
    checks++; if (bus.out_count !== 3'd4) begin errors++; $display("FAIL pool_count got %0d exp 4", bus.out_count); end
    tick();
  endtask

  task automatic test_flush();
    bus.pool_len = 2'd3; bus.out_ready = 1'b0;
    send(8'h01); send(8'h09);
    bus.pool_len = 2'd0;
    send(8'h04);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_midlen_valid got %b exp 0", bus.out_valid); end
    bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    checks++; if (bus.out_word !== 32'h09000000) begin errors++; $display("FAIL flush_word got %h exp 09000000", bus.out_word); end
    checks++; if (bus.out_count !== 3'd1) begin errors++; $display("FAIL flush_count got %0d exp 1", bus.out_count); end
    bus.out_ready = 1'b1; bus.flush = 1'b1; tick(); bus.flush = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty_noop got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_w;
    bus.pool_len = 2'd0; bus.relu_en = 1'b0; bus.out_ready = 1'b0;
    for (int k = 0; k < 24; k++) begin
      send(8'(k + 1));
      if (k == 15 || k == 23) begin
        checks++; if (bus.out_word !== 32'h01020304) begin errors++; $display("FAIL ovf_head_hold k=%0d got %h exp 01020304", k, bus.out_word); end
      end
      if (k == 18) begin
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", bus.overflow); end
      end
      if (k == 19) begin
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", bus.overflow); end
      end
    end
    bus.out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      exp_w = {8'(4*n+1), 8'(4*n+2), 8'(4*n+3), 8'(4*n+4)};
      checks++; if (bus.out_word !== exp_w || bus.out_valid !== 1'b1) begin errors++; $display("FAIL ovf_drain%0d got %h v=%b exp %h", n, bus.out_word, bus.out_valid, exp_w); end
      tick();
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", bus.out_valid); end
    checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus.overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] exp_w [5];
    exp_w = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'h11121314};
    do_reset();
    bus.pool_len = 2'd0; bus.out_ready = 1'b0;
    for (int k = 0; k < 19; k++) send(8'(k + 1));
    bus.in_data = 8'h14; bus.in_en = 1'b1; bus.flush = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_en = 1'b0; bus.flush = 1'b0;
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL full_overflow got %b exp 0", bus.overflow); end
    for (int n = 1; n < 5; n++) begin
      checks++; if (bus.out_word !== exp_w[n] || bus.out_count !== 3'd4) begin errors++; $display("FAIL full_drain%0d got %h c=%0d exp %h c=4", n, bus.out_word, bus.out_count, exp_w[n]); end
      tick();
    end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_single_push got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    bus.pool_len = 2'd0; bus.out_ready = 1'b0;
    send(8'h31); send(8'h32); send(8'h33); send(8'h34);
    send(8'hAA); send(8'hBB);
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_word !== 32'h0 || bus.out_count !== 3'd0 || bus.overflow !== 1'b0)
      begin errors++; $display("FAIL rst_mid_outputs got v=%b w=%h c=%0d o=%b exp all 0", bus.out_valid, bus.out_word, bus.out_count, bus.overflow); end
    bus.out_ready = 1'b1;
    send(8'h21); send(8'h22); send(8'h23); send(8'h24);
    checks++; if (bus.out_word !== 32'h21222324) begin errors++; $display("FAIL rst_mid_word got %h exp 21222324", bus.out_word); end
    checks++; if (bus.out_count !== 3'd4) begin errors++; $display("FAIL rst_mid_count got %0d exp 4", bus.out_count); end
    tick();
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    bus.in_data = '0; bus.in_en = 1'b0; bus.relu_en = 1'b0; bus.pool_len = 2'd0;
    bus.flush = 1'b0; bus.out_ready = 1'b0;
    test_reset();
    test_relu();
    test_pool();
    test_flush();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
